mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port unified memory between instruction fetch and the load/store path of the RISC-V core. It runs a req/gnt handshake on each side and drives one memory access at a time with byte enables derived from the access size. It waits on the memory's ready, returns data and a one-cycle completion pulse to the winner, and reports misalignment and timeout errors. It sits between the fetch/LSU stages and the memory model, under control of the decoder's store/load-size outputs.

## Interface
- ADDR_W, 32, address width
- TIMEOUT, 15, max access cycles waiting for mem_ready before abort (≥1)
- STARVE_LIMIT, 4, consecutive LSU grants tolerated while fetch waits (only with guard compiled in)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request (level)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant pulse
- if_rdata  out  32  fetched word, registered
- if_valid  out  1  one-cycle completion pulse
- if_err  out  1  one-cycle error pulse (misaligned or timeout)
- ls_req  in  1  LSU request (level)
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ls_addr  in  ADDR_W  byte address
- ls_wdata  in  32  store data, right-aligned
- ls_gnt / ls_rdata / ls_valid / ls_err  out  1/32/1/1  as fetch side; ls_rdata is the raw memory word
- mem_en  out  1  access active
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid when mem_ready=1
- mem_ready  in  1  access complete
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACC.
- IDLE: when only one req is high, that side wins. When both are high, LSU wins (strict priority).
  - Winner's gnt pulses this cycle. Address, we, size and wdata are latched.
  - Aligned request: go to ACC.
  - Misaligned request: no memory access; the winner's err pulses next cycle; stay IDLE.
- Misaligned means: fetch addr[1:0]≠0; half with addr[0]=1; word with addr[1:0]≠0.
- ACC: mem_en=1 and latched fields are held stable.
  - mem_ready=1: capture mem_rdata into the winner's rdata (loads and fetch only; stores leave rdata unchanged). Pulse valid next cycle. Go to IDLE.
- Byte enables and write data:
  - Byte: mem_be=0001<<addr[1:0], mem_wdata = byte replicated ×4.
  - Half: mem_be=0011<<(2·addr[1]), mem_wdata = half replicated ×2.
  - Word: mem_be=1111.
  - mem_we=0 forces mem_be=1111 on loads and fetch.
- Timeout: a counter starts at 1 on the first ACC cycle.
  - If mem_ready=0 on ACC cycle TIMEOUT, drop mem_en, pulse err next cycle, go to IDLE.
  - mem_ready=1 on that same cycle counts as completion, not timeout.
- The req input of the side being serviced is ignored during ACC. A req still high when the FSM returns to IDLE is a new request. Requesters drop req the cycle after gnt unless issuing another access.

## Timing
- Reset, any time: state=IDLE; all outputs 0, including rdata registers and counters. An in-flight access is abandoned with no valid or err pulse.
- Cycle 0: grant in IDLE. Cycles 1..k: ACC, with mem_ready at cycle k. Cycle k+1: valid pulse, and IDLE may grant again in the same cycle.
- Minimum request→valid latency is 2 cycles. Peak throughput is one access per 2 cycles.
- err and valid are never asserted together on the same port.
- On a misaligned request followed by a grant in the next cycle, the err pulse for one port and the next gnt may coincide.
- gnt is never high on both ports in the same cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A fetch-wait counter increments on each LSU grant while if_req=1.
  - It clears on any fetch grant or when if_req=0.
  - When the counter equals STARVE_LIMIT and both reqs are high, fetch wins.
- ARB_STARVE_GUARD_EN undefined: strict LSU priority; counter and STARVE_LIMIT logic absent.

## Test plan
- Fetch, addr 0x100, mem_ready on first ACC cycle, mem_rdata 0x00500093 → if_gnt cycle 0, mem_en cycle 1, if_valid with if_rdata=0x00500093 in cycle 2.
- Store byte 0xAB at 0x203 → mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x200, ls_valid pulse, ls_rdata unchanged.
- if_req and ls_req high in the same cycle → ls_gnt only; if_gnt on the first IDLE cycle after ls_valid.
- Load half at 0x101 → ls_gnt, ls_err next cycle, mem_en never asserted.
- TIMEOUT=3, mem_ready held 0 → mem_en high for exactly 3 cycles, then ls_err pulse; busy returns to 0.
- Guard build, STARVE_LIMIT=4, both reqs held high → 4 LSU grants, then 1 fetch grant, repeating. Non-guard build: LSU only.
- rst asserted mid-ACC → outputs 0 immediately; no valid or err pulse afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and the LSU.
// Define ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT LSU grants.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic [31:0]       ls_rdata,
    output logic              ls_valid,
    output logic              ls_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);
    typedef enum logic {IDLE, ACC} state_t;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q;
    logic              side_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              if_valid_q, if_err_q, ls_valid_q, ls_err_q;
    logic [31:0]       if_rdata_q, ls_rdata_q;

    logic              idle;
    logic              fetch_pref;
    logic [ADDR_W-1:0] g_addr;
    logic [1:0]        g_size;
    logic              g_we;
    logic              mis;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q;

    assign fetch_pref = (starve_q == SW'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (if_gnt || !if_req) begin
            starve_q <= '0;
        end else if (ls_gnt) begin
            starve_q <= starve_q + SW'(1);
        end
    end
`else
    assign fetch_pref = (STARVE_LIMIT < 0);
`endif

    // Grants are combinational so the winner sees gnt in its request cycle.
    assign idle   = (state_q == IDLE) && !rst;
    assign ls_gnt = idle && ls_req && !(if_req && fetch_pref);
    assign if_gnt = idle && if_req && !ls_gnt;

    assign g_addr = ls_gnt ? ls_addr : if_addr;
    assign g_size = ls_gnt ? ls_size : 2'b10;
    assign g_we   = ls_gnt && ls_we;

    always_comb begin
        mis     = 1'b0;
        be_d    = 4'hf;
        wdata_d = ls_wdata;
        case (g_size)
            2'b00: begin
                be_d    = 4'b0001 << g_addr[1:0];
                wdata_d = {4{ls_wdata[7:0]}};
            end
            2'b01: begin
                mis     = g_addr[0];
                be_d    = 4'b0011 << {g_addr[1], 1'b0};
                wdata_d = {2{ls_wdata[15:0]}};
            end
            default: mis = |g_addr[1:0];
        endcase
        if (!g_we) be_d = 4'hf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            side_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            ls_valid_q <= 1'b0;
            ls_err_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            ls_valid_q <= 1'b0;
            ls_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (if_gnt || ls_gnt) begin
                        side_q  <= ls_gnt;
                        we_q    <= g_we;
                        addr_q  <= {g_addr[ADDR_W-1:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        cnt_q   <= CNT_W'(1);
                        if (mis) begin
                            if_err_q <= if_gnt;
                            ls_err_q <= ls_gnt;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (mem_ready) begin
                        state_q <= IDLE;
                        if (side_q) begin
                            ls_valid_q <= 1'b1;
                            if (!we_q) ls_rdata_q <= mem_rdata;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        state_q  <= IDLE;
                        if_err_q <= !side_q;
                        ls_err_q <= side_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign mem_en    = (state_q == ACC);
    assign busy      = mem_en;
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_be    = mem_en ? be_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign if_valid  = if_valid_q;
    assign if_err    = if_err_q;
    assign ls_valid  = ls_valid_q;
    assign ls_err    = ls_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a
// transaction-level model of grants, byte lanes, completion and errors.
module tb_mem_arbiter;
    localparam int TO = 3;
    localparam int SL = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_size;
    logic        if_gnt, if_valid, if_err, ls_gnt, ls_valid, ls_err;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_en, mem_we, mem_ready, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] if_rd_m, ls_rd_m;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rdata(ls_rdata), .ls_valid(ls_valid), .ls_err(ls_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic fetch, input logic [1:0] size);
        if (fetch || size >= 2'd2) return 4;
        return (size == 2'd0) ? 1 : 2;
    endfunction

    function automatic logic [3:0] m_be(input logic fetch, input logic we,
                                        input logic [1:0] size,
                                        input logic [31:0] addr);
        logic [3:0] be;
        int n, off;
        be  = 4'h0;
        n   = nbytes(fetch, size);
        off = int'(addr % 4);
        if (fetch || !we) return 4'hf;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size,
                                            input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(1'b0, size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    // One complete transaction; lat = ACC cycle that raises mem_ready
    // (lat > TO means the memory never answers within the window).
    task automatic access(input bit ireq, input bit lreq,
                          input logic [31:0] iaddr, input logic lwe,
                          input logic [1:0] lsize, input logic [31:0] laddr,
                          input logic [31:0] lwdata, input int lat,
                          input logic [31:0] rd);
        bit w_ls, fetch, mis, done, ewe;
        logic [31:0] a;
        int n;
        @(negedge clk);
        if_req = ireq; ls_req = lreq; if_addr = iaddr;
        ls_we = lwe; ls_size = lsize; ls_addr = laddr; ls_wdata = lwdata;
        mem_ready = 1'b0;
        #1;
        w_ls  = lreq;
        fetch = !w_ls;
        a     = w_ls ? laddr : iaddr;
        n     = nbytes(fetch, lsize);
        mis   = (a % n) != 0;
        ewe   = w_ls && lwe;
        chk("if_gnt", if_gnt, !w_ls);
        chk("ls_gnt", ls_gnt, w_ls);
        chk("busy_idle", busy, 0);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        #1;
        if (mis) begin
            chk("mis_err", w_ls ? ls_err : if_err, 1);
            chk("mis_valid", w_ls ? ls_valid : if_valid, 0);
            chk("mis_mem_en", mem_en, 0);
            return;
        end
        for (int k = 1; k <= TO; k++) begin
            chk("mem_en", mem_en, 1);
            chk("mem_addr", mem_addr, a & ~32'h3);
            chk("mem_we", mem_we, ewe);
            chk("mem_be", mem_be, m_be(fetch, lwe, lsize, a));
            if (ewe) chk("mem_wdata", mem_wdata, m_wdata(lsize, lwdata));
            mem_ready = (k == lat);
            mem_rdata = rd;
            if (k == lat || k == TO) break;
            @(negedge clk); #1;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        done = (lat >= 1 && lat <= TO);
        if (done && (fetch || !lwe)) begin
            if (fetch) if_rd_m = rd;
            else ls_rd_m = rd;
        end
        chk("valid", w_ls ? ls_valid : if_valid, done);
        chk("err", w_ls ? ls_err : if_err, !done);
        chk("other_valid", w_ls ? if_valid : ls_valid, 0);
        chk("other_err", w_ls ? if_err : ls_err, 0);
        chk("if_rdata", if_rdata, if_rd_m);
        chk("ls_rdata", ls_rdata, ls_rd_m);
        chk("mem_en_end", mem_en, 0);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        int starve, ngr;
        bit exp_if;
        rst = 1'b1;
        if_req = 0; ls_req = 0; ls_we = 0; ls_size = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        if_rd_m = 0; ls_rd_m = 0;

        @(negedge clk); #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        chk("rst_pulses", {if_valid, if_err, ls_valid, ls_err}, 0);
        chk("rst_mem_be", mem_be, 0);
        @(negedge clk);
        rst = 1'b0;

        access(1, 0, 32'h100, 0, 2'b10, 0, 0, 1, 32'h0050_0093);
        access(0, 1, 0, 1, 2'b00, 32'h203, 32'hAB, 1, 32'hDEAD_BEEF);
        access(0, 1, 0, 0, 2'b01, 32'h101, 0, 1, 32'h1234_5678);
        access(0, 1, 0, 0, 2'b10, 32'h40, 0, TO + 1, 32'h1);
        access(0, 1, 0, 1, 2'b01, 32'h302, 32'hCAFE, 2, 0);
        access(0, 1, 0, 0, 2'b11, 32'h344, 0, 3, 32'h7777_1111);

        // Both request: LSU first, fetch granted in the cycle ls_valid fires.
        @(negedge clk);
        if_req = 1; ls_req = 1; if_addr = 32'h200;
        ls_we = 0; ls_size = 2'b10; ls_addr = 32'h300;
        #1;
        chk("both_ls_gnt", ls_gnt, 1);
        chk("both_if_gnt", if_gnt, 0);
        @(negedge clk);
        ls_req = 0; mem_rdata = 32'h1111_2222;
        #1;
        chk("both_acc_if_gnt", if_gnt, 0);
        chk("both_acc_addr", mem_addr, 32'h300);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        #1;
        ls_rd_m = 32'h1111_2222;
        chk("both_ls_valid", ls_valid, 1);
        chk("both_ls_rdata", ls_rdata, ls_rd_m);
        chk("both_if_gnt2", if_gnt, 1);
        @(negedge clk);
        if_req = 0; mem_rdata = 32'h3333_4444;
        #1;
        chk("both_if_addr", mem_addr, 32'h200);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        #1;
        if_rd_m = 32'h3333_4444;
        chk("both_if_valid", if_valid, 1);
        chk("both_if_rdata", if_rdata, if_rd_m);

        // Both held high with a one-cycle memory.
        @(negedge clk);
        if_req = 1; ls_req = 1; if_addr = 32'h400; ls_addr = 32'h500;
        ls_we = 0; ls_size = 2'b10; mem_rdata = 32'h5A5A_0F0F;
        starve = 0; ngr = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            chk("one_hot_gnt", {31'd0, if_gnt && ls_gnt}, 0);
            if (if_gnt || ls_gnt) begin
                exp_if = GUARD && (starve == SL);
                chk("hold_if_gnt", if_gnt, exp_if);
                chk("hold_ls_gnt", ls_gnt, !exp_if);
                if (exp_if) begin
                    starve = 0;
                    if_rd_m = mem_rdata;
                end else begin
                    starve++;
                    ls_rd_m = mem_rdata;
                end
                ngr++;
            end
            mem_ready = busy;
            @(negedge clk);
        end
        if_req = 0; ls_req = 0;
        #1;
        mem_ready = 0;
        chk("hold_grants", ngr, 12);
        chk("hold_ls_rdata", ls_rdata, ls_rd_m);
        chk("hold_if_rdata", if_rdata, if_rd_m);

        for (int t = 0; t < 40; t++) begin
            int sel;
            logic [31:0] ia, la;
            sel = $urandom_range(0, 2);
            ia  = ($urandom & 32'h0000_FFFC) |
                  (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0);
            la  = $urandom & 32'h0000_FFFF;
            access(sel != 1, sel != 0, ia, 1'($urandom),
                   2'($urandom_range(0, 3)), la, $urandom,
                   $urandom_range(1, TO + 1), $urandom);
        end

        // Reset in the middle of an access.
        @(negedge clk);
        ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_addr = 32'h80;
        #1;
        chk("midrst_gnt", ls_gnt, 1);
        @(negedge clk);
        ls_req = 0;
        #1;
        chk("midrst_mem_en", mem_en, 1);
        rst = 1;
        #1;
        if_rd_m = 0; ls_rd_m = 0;
        chk("midrst_mem_en0", mem_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_if_rdata", if_rdata, if_rd_m);
        chk("midrst_ls_rdata", ls_rdata, ls_rd_m);
        @(negedge clk);
        rst = 0;
        mem_ready = 1;
        repeat (4) begin
            @(negedge clk); #1;
            chk("post_rst_pulses", {ls_valid, ls_err, if_valid, if_err}, 0);
            chk("post_rst_busy", busy, 0);
        end
        mem_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
